note_sequencer: RTL and testbench

Scheduler in front of the sound generator's `period` input. The CPU side, via memIO on clk12, enqueues notes as {period, duration} pairs into a small FIFO. The block plays them back-to-back, drives each period for its duration in millisecond ticks, and inserts a fixed silent gap between notes. This frees the MIPS program from busy-wait timing loops for music and effects.

---
 rtl/note_sequencer.sv | 135 +++++++++++++
 tb/tb_note_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// Note scheduler for the sound generator: queues {period, duration} pairs and
// plays them back-to-back in millisecond ticks, with an optional silent gap.
module note_sequencer #(
  parameter int wordsize  = 32,
  parameter int depth     = 8,
  parameter int dur_bits  = 16,
  parameter int tick_div  = 12500,
  parameter int gap_ticks = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [wordsize-1:0]      wr_period,
  input  logic [dur_bits-1:0]      wr_duration,
  input  logic                     flush,
  output logic [wordsize-1:0]      period,
  output logic                     busy,
  output logic                     full,
  output logic [$clog2(depth):0]   count,
  output logic                     overflow
);

  localparam int aw = $clog2(depth);
  localparam int cw = aw + 1;
  localparam int pw = (tick_div > 1) ? $clog2(tick_div) : 1;
  localparam int gw = $clog2(gap_ticks + 1);
  localparam int mw = (dur_bits > gw) ? dur_bits : gw;
  localparam logic [pw-1:0] presc_max = pw'(tick_div - 1);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t                state, state_n;
  logic [wordsize-1:0]   mem_period [depth];
  logic [dur_bits-1:0]   mem_dur    [depth];
  logic [aw-1:0]         wr_ptr, rd_ptr;
  logic [pw-1:0]         presc, presc_n;
  logic [mw-1:0]         ms_cnt, ms_n;
  logic [wordsize-1:0]   period_n;
  logic [cw-1:0]         count_n;
  logic                  push, pop, tick, last;

  // The ms counter holds either the note duration (PLAY) or gap_ticks (GAP);
  // it never sits at zero in those states, so "last" is its final wrap.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    state_n  = state;
    pop      = 1'b0;
    period_n = period;
    tick     = (presc == presc_max);
    last     = tick && (ms_cnt == mw'(1));
    presc_n  = tick ? '0 : presc + pw'(1);
    ms_n     = tick ? ms_cnt - mw'(1) : ms_cnt;
    push     = wr_en && !full && !flush;

    unique case (state)
      IDLE: begin
        period_n = '0;
        presc_n  = '0;
        if (count != '0) pop = 1'b1;
      end
      PLAY: begin
        if (last) begin
          if (gap_ticks != 0) begin
            state_n  = GAP;
            period_n = '0;
            ms_n     = mw'(gap_ticks);
            presc_n  = '0;
          end else if (count != '0) begin
            pop = 1'b1;
          end else begin
            state_n  = IDLE;
            period_n = '0;
          end
        end
      end
      GAP: begin
        if (last) begin
          if (count != '0) pop = 1'b1;
          else             state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // A popped zero-length note is discarded; IDLE retries next cycle.
    if (pop) begin
      presc_n = '0;
      if (mem_dur[rd_ptr] == '0) begin
        state_n  = IDLE;
        period_n = '0;
      end else begin
        state_n  = PLAY;
        period_n = mem_period[rd_ptr];
        ms_n     = mw'(mem_dur[rd_ptr]);
      end
    end

    count_n = count + cw'(push) - cw'(pop);
  end

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      state    <= IDLE;
      period   <= '0;
      busy     <= 1'b0;
      full     <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      presc    <= '0;
      ms_cnt   <= '0;
    end else begin
      state    <= state_n;
      period   <= period_n;
      count    <= count_n;
      busy     <= (state_n != IDLE) || (count_n != '0);
      full     <= (count_n == cw'(depth));
      overflow <= overflow | (wr_en & full);
      presc    <= presc_n;
      ms_cnt   <= ms_n;
      if (push) wr_ptr <= wr_ptr + aw'(1);
      if (pop)  rd_ptr <= rd_ptr + aw'(1);
    end
  end

  // NOTE: storage has no reset; the cleared pointers and count make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_period[wr_ptr] <= wr_period;
      mem_dur[wr_ptr]    <= wr_duration;
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: one instance with a 2-tick gap and one with no gap,
// both checked every cycle against a queue-and-countdown reference model.
module tb_note_sequencer;

  localparam int td = 4;
  localparam int dp = 8;

  logic        clk = 1'b0;
  logic        reset, wr_en, flush;
  logic [31:0] wr_period;
  logic [15:0] wr_duration;

  logic [31:0] period_g, period_z;
  logic        busy_g, busy_z, full_g, full_z, overflow_g, overflow_z;
  logic [3:0]  count_g, count_z;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  note_sequencer #(.wordsize(32), .depth(dp), .dur_bits(16), .tick_div(td), .gap_ticks(2)) u_gap (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_period(wr_period), .wr_duration(wr_duration),
    .flush(flush), .period(period_g), .busy(busy_g), .full(full_g), .count(count_g),
    .overflow(overflow_g)
  );

  note_sequencer #(.wordsize(32), .depth(dp), .dur_bits(16), .tick_div(td), .gap_ticks(0)) u_nogap (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_period(wr_period), .wr_duration(wr_duration),
    .flush(flush), .period(period_z), .busy(busy_z), .full(full_z), .count(count_z),
    .overflow(overflow_z)
  );

  // Reference model: a note queue plus remaining-cycle countdowns per instance.
  typedef struct {
    int unsigned per;
    int unsigned dur;
  } note_t;

  note_t       q0[$], q1[$];
  int unsigned m_play[2], m_gap[2], m_per[2];
  bit          m_ovf[2];

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic note_t qpop(input int i);
    if (i == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  function automatic void qpush(input int i, input note_t n);
    if (i == 0) q0.push_back(n);
    else        q1.push_back(n);
  endfunction

  function automatic void qclear(input int i);
    if (i == 0) q0.delete();
    else        q1.delete();
  endfunction

  task automatic model_step(input int i, input int unsigned gap);
    bit    was_full, need_pop;
    note_t n;
    was_full = (qsize(i) == dp);
    if (!reset || flush) begin
      qclear(i);
      m_play[i] = 0;
      m_gap[i]  = 0;
      m_per[i]  = 0;
      m_ovf[i]  = 1'b0;
    end else begin
      need_pop = 1'b0;
      if (m_play[i] != 0) begin
        m_play[i]--;
        if (m_play[i] == 0) begin
          if (gap != 0) begin
            m_gap[i] = gap * td;
            m_per[i] = 0;
          end else begin
            need_pop = 1'b1;
          end
        end
      end else if (m_gap[i] != 0) begin
        m_gap[i]--;
        if (m_gap[i] == 0) need_pop = 1'b1;
      end else begin
        need_pop = 1'b1;
      end
      if (need_pop) begin
        m_per[i] = 0;
        if (qsize(i) != 0) begin
          n = qpop(i);
          if (n.dur != 0) begin
            m_play[i] = n.dur * td;
            m_per[i]  = n.per;
          end
        end
      end
      if (wr_en) begin
        if (was_full) m_ovf[i] = 1'b1;
        else begin
          n.per = wr_period;
          n.dur = 32'(wr_duration);
          qpush(i, n);
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("gap.period",   period_g,          m_per[0]);
    check("gap.count",    32'(count_g),      32'(qsize(0)));
    check("gap.full",     32'(full_g),       32'(qsize(0) == dp));
    check("gap.busy",     32'(busy_g),       32'(m_play[0] != 0 || m_gap[0] != 0 || qsize(0) != 0));
    check("gap.overflow", 32'(overflow_g),   32'(m_ovf[0]));
    check("nogap.period", period_z,          m_per[1]);
    check("nogap.count",  32'(count_z),      32'(qsize(1)));
    check("nogap.full",   32'(full_z),       32'(qsize(1) == dp));
    check("nogap.busy",   32'(busy_z),       32'(m_play[1] != 0 || m_gap[1] != 0 || qsize(1) != 0));
    check("nogap.ovf",    32'(overflow_z),   32'(m_ovf[1]));
  endtask

  // One clock: DUTs and model advance on the rising edge, outputs compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step(0, 2);
    model_step(1, 0);
    @(negedge clk);
    check_all();
  endtask

  task automatic step(input bit we, input int unsigned p, input int unsigned d, input bit fl);
    wr_en       = we;
    wr_period   = p;
    wr_duration = 16'(d);
    flush       = fl;
    cycle();
    wr_en = 1'b0;
    flush = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    bit seen300, seen400;
    reset = 1'b0; wr_en = 1'b0; flush = 1'b0; wr_period = '0; wr_duration = '0;
    idle(2);
    check("rst.period",   period_g,          0);
    check("rst.busy",     32'(busy_g),       0);
    check("rst.count",    32'(count_g),      0);
    check("rst.overflow", 32'(overflow_g),   0);
    reset = 1'b1;
    idle(2);

    // Single note {1000,3}: 2-edge latency, 12 cycles of tone, 8 cycles of gap.
    step(1'b1, 1000, 3, 1'b0);
    check("t1.count1", 32'(count_g), 1);
    check("t1.lat0",   period_g, 0);
    cycle();
    check("t1.start",  period_g, 1000);
    idle(11);
    check("t1.end",    period_g, 1000);
    cycle();
    check("t1.gap0",   period_g, 0);
    check("t1.gapbusy", 32'(busy_g), 1);
    idle(7);
    check("t1.gapend", 32'(busy_g), 1);
    cycle();
    check("t1.idle",   32'(busy_g), 0);
    idle(4);

    // Fill to depth behind a long note, then overflow on the ninth write.
    step(1'b1, 50, 20, 1'b0);
    idle(2);
    for (int i = 0; i < 8; i++) step(1'b1, 100 * (i + 1), 1 + (i % 2), 1'b0);
    check("t2.count8", 32'(count_g), 8);
    check("t2.full",   32'(full_g), 1);
    step(1'b1, 999, 1, 1'b0);
    check("t2.drop",   32'(count_g), 8);
    check("t2.ovf",    32'(overflow_g), 1);
    idle(300);
    check("t2.drain",  32'(count_g), 0);
    check("t2.busy0",  32'(busy_g), 0);
    check("t2.sticky", 32'(overflow_g), 1);

    // Flush mid-note with entries queued and a concurrent write.
    step(1'b1, 60, 10, 1'b0);
    idle(2);
    step(1'b1, 11, 1, 1'b0);
    step(1'b1, 22, 1, 1'b0);
    step(1'b1, 33, 1, 1'b0);
    idle(3);
    check("t5.playing", period_g, 60);
    check("t5.queued",  32'(count_g), 3);
    step(1'b1, 44, 1, 1'b1);
    check("t5.period0", period_g, 0);
    check("t5.count0",  32'(count_g), 0);
    check("t5.busy0",   32'(busy_g), 0);
    check("t5.ovfclr",  32'(overflow_g), 0);
    idle(3);
    check("t5.nowrite", 32'(count_g), 0);
    check("t5.silent",  period_g, 0);

    // No-gap instance: 500 for 8 cycles, 700 on the very next cycle for 4.
    step(1'b1, 500, 2, 1'b0);
    check("t3.count1", 32'(count_z), 1);
    step(1'b1, 700, 1, 1'b0);
    check("t3.start",  period_z, 500);
    idle(7);
    check("t3.last500", period_z, 500);
    cycle();
    check("t3.next700", period_z, 700);
    idle(3);
    check("t3.last700", period_z, 700);
    cycle();
    check("t3.silent",  period_z, 0);
    idle(30);

    // Zero-duration note between two real ones never reaches the output.
    step(1'b1, 300, 1, 1'b0);
    step(1'b1, 77, 0, 1'b0);
    step(1'b1, 400, 1, 1'b0);
    seen300 = 1'b0;
    seen400 = 1'b0;
    for (int k = 0; k < 30; k++) begin
      cycle();
      check("t4.no77", 32'(period_g == 32'd77), 0);
      if (period_g == 32'd300) seen300 = 1'b1;
      if (period_g == 32'd400) seen400 = 1'b1;
    end
    check("t4.seen300", 32'(seen300), 1);
    check("t4.seen400", 32'(seen400), 1);

    // One-cycle reset in the middle of a gap, then normal latency again.
    step(1'b1, 900, 1, 1'b0);
    idle(6);
    check("t6.ingap", 32'(busy_g), 1);
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    check("t6.period", period_g, 0);
    check("t6.busy",   32'(busy_g), 0);
    check("t6.count",  32'(count_g), 0);
    step(1'b1, 123, 2, 1'b0);
    check("t6.lat0",   period_g, 0);
    cycle();
    check("t6.start",  period_g, 123);
    idle(20);

    // Randomized traffic with occasional flush and reset.
    for (int k = 0; k < 600; k++) begin
      reset = ($urandom_range(0, 149) != 0);
      step($urandom_range(0, 2) == 0, $urandom_range(0, 3000), $urandom_range(0, 3),
           $urandom_range(0, 79) == 0);
    end
    reset = 1'b1;
    idle(200);
    check("rand.quiet", 32'(busy_g), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
